// File: rtl/axi_spy_drain_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : axi_spy_drain_arb                                               |
// | Purpose  : Drains four AXI spy FIFOs (AR, AW, R, W) into a single trace    |
// |            stream. Full FIFOs win over non-full ones; round-robin inside   |
// |            each class. One entry per IDLE->FETCH->LATCH->SEND pass.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module axi_spy_drain_arb #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  ar_empty,
  input  logic                  aw_empty,
  input  logic                  r_empty,
  input  logic                  w_empty,
  input  logic                  ar_full,
  input  logic                  aw_full,
  input  logic                  r_full,
  input  logic                  w_full,
  output logic                  ar_rd_en,
  output logic                  aw_rd_en,
  output logic                  r_rd_en,
  output logic                  w_rd_en,
  input  logic [ADDR_WIDTH-1:0] ar_dout,
  input  logic [ADDR_WIDTH-1:0] aw_dout,
  input  logic [DATA_WIDTH-1:0] r_dout,
  input  logic [DATA_WIDTH-1:0] w_dout,
  output logic                  trace_valid,
  input  logic                  trace_ready,
  output logic [DATA_WIDTH-1:0] trace_data,
  output logic [1:0]            trace_src,
  output logic                  trace_urgent,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  drain_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LATCH = 2'd2,
    SEND  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            grant_q, grant_d;
  logic [1:0]            last_grant_q, last_grant_d;
  logic                  urgent_q, urgent_d;
  logic [DATA_WIDTH-1:0] trace_data_q, trace_data_d;
  logic [CNT_WIDTH-1:0]  drain_cnt_q, drain_cnt_d;

  logic [3:0]            empty_v, full_v, cand_v, rd_en_v;
  logic [1:0]            pick_idx;
  logic                  pick_found;

  assign empty_v = {w_empty, r_empty, aw_empty, ar_empty};
  assign full_v  = {w_full,  r_full,  aw_full,  ar_full};

  // Arbitration: restrict to full non-empty channels when any exist, then
  // take the first candidate searching from last_grant+1 upward (mod 4).
  always_comb begin
    logic [1:0] idx;
    cand_v     = full_v & ~empty_v;
    if (cand_v == 4'b0000) begin
      cand_v = ~empty_v;
    end
    pick_found = 1'b0;
    pick_idx   = 2'd0;
    idx        = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = last_grant_q + 2'(i + 1);
      if (!pick_found && cand_v[idx]) begin
        pick_found = 1'b1;
        pick_idx   = idx;
      end
    end
  end

  // Next-state and output decode for the drain sequencer.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    urgent_d     = urgent_q;
    trace_data_d = trace_data_q;
    drain_cnt_d  = drain_cnt_q;
    rd_en_v      = 4'b0000;
    trace_valid  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable && pick_found) begin
          grant_d  = pick_idx;
          urgent_d = full_v[pick_idx];
          state_d  = FETCH;
        end
      end
      FETCH: begin
        rd_en_v[grant_q] = 1'b1;
        state_d          = LATCH;
      end
      LATCH: begin
        unique case (grant_q)
          2'd0:    trace_data_d = DATA_WIDTH'(ar_dout);
          2'd1:    trace_data_d = DATA_WIDTH'(aw_dout);
          2'd2:    trace_data_d = r_dout;
          default: trace_data_d = w_dout;
        endcase
        state_d = SEND;
      end
      SEND: begin
        trace_valid = 1'b1;
        if (trace_ready) begin
          state_d      = IDLE;
          last_grant_d = grant_q;
          if (drain_cnt_q != {CNT_WIDTH{1'b1}}) begin
            drain_cnt_d = drain_cnt_q + CNT_WIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; last_grant resets to W so AR goes first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= 2'd0;
      last_grant_q <= 2'd3;
      urgent_q     <= 1'b0;
      trace_data_q <= '0;
      drain_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      urgent_q     <= urgent_d;
      trace_data_q <= trace_data_d;
      drain_cnt_q  <= drain_cnt_d;
    end
  end

  assign ar_rd_en     = rd_en_v[0];
  assign aw_rd_en     = rd_en_v[1];
  assign r_rd_en      = rd_en_v[2];
  assign w_rd_en      = rd_en_v[3];
  assign trace_data   = trace_data_q;
  assign trace_src    = grant_q;
  assign trace_urgent = (state_q == SEND) && urgent_q;
  assign busy         = (state_q != IDLE);
  assign drain_cnt    = drain_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_spy_drain_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_axi_spy_drain_arb                                            |
// | Purpose  : Directed + random bench; four modelled spy FIFOs feed the DUT   |
// |            and a priority-score reference predicts every trace entry.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_axi_spy_drain_arb;
  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int CW  = 4;
  localparam int CAP = 3;               // FIFO reports full at this occupancy
  localparam int MAXCNT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n, enable, trace_ready;
  logic ar_empty, aw_empty, r_empty, w_empty;
  logic ar_full, aw_full, r_full, w_full;
  logic ar_rd_en, aw_rd_en, r_rd_en, w_rd_en;
  logic [AW-1:0] ar_dout, aw_dout;
  logic [DW-1:0] r_dout, w_dout;
  logic          trace_valid, trace_urgent, busy;
  logic [DW-1:0] trace_data;
  logic [1:0]    trace_src;
  logic [CW-1:0] drain_cnt;

  axi_spy_drain_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .ar_empty(ar_empty), .aw_empty(aw_empty), .r_empty(r_empty), .w_empty(w_empty),
    .ar_full(ar_full), .aw_full(aw_full), .r_full(r_full), .w_full(w_full),
    .ar_rd_en(ar_rd_en), .aw_rd_en(aw_rd_en), .r_rd_en(r_rd_en), .w_rd_en(w_rd_en),
    .ar_dout(ar_dout), .aw_dout(aw_dout), .r_dout(r_dout), .w_dout(w_dout),
    .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_data(trace_data),
    .trace_src(trace_src), .trace_urgent(trace_urgent), .busy(busy), .drain_cnt(drain_cnt)
  );

  always #5 clk = ~clk;

  // FIFO contents as circular arrays, plus the reference bookkeeping.
  logic [63:0] mem [4][64];
  int          head [4];
  int          tail [4];
  int          k;          // cycles since the grant edge, 0 when no drain is active
  int          gch;
  logic        gurg;
  logic [63:0] gdata;
  int          last;
  int          exp_cnt;
  int          n_cmp, n_err;
  logic [1:0]  src_log [$];
  logic        urg_log [$];
  logic [63:0] data_log [$];

  function automatic int fsize(int c);
    return tail[c] - head[c];
  endfunction

  task automatic push(int c, logic [63:0] v);
    mem[c][tail[c] % 64] = v;
    tail[c]++;
  endtask

  task automatic push_rand(int c);
    logic [63:0] v;
    v = (c < 2) ? {32'h0, $urandom()} : {$urandom(), $urandom()};
    push(c, v);
  endtask

  task automatic flush();
    for (int c = 0; c < 4; c++) head[c] = tail[c];
    src_log.delete(); urg_log.delete(); data_log.delete();
  endtask

  task automatic update_flags();
    ar_empty = (fsize(0) == 0); aw_empty = (fsize(1) == 0);
    r_empty  = (fsize(2) == 0); w_empty  = (fsize(3) == 0);
    ar_full  = (fsize(0) >= CAP); aw_full = (fsize(1) >= CAP);
    r_full   = (fsize(2) >= CAP); w_full  = (fsize(3) >= CAP);
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Score = 0 for a full FIFO else 4, plus distance after the last winner; lowest wins.
  function automatic int pick();
    int best, bs, s;
    best = -1; bs = 99;
    for (int c = 0; c < 4; c++) begin
      if (fsize(c) > 0) begin
        s = ((fsize(c) >= CAP) ? 0 : 4) + ((c - last + 3) % 4);
        if (s < bs) begin bs = s; best = c; end
      end
    end
    return best;
  endfunction

  // One clock: check outputs mid-cycle, predict this edge, then serve FIFO pops.
  task automatic cycle();
    int          pop_ch, k_next, p;
    logic [3:0]  rd_obs, rd_exp;
    logic [63:0] v;
    update_flags();
    #1;
    rd_obs = {w_rd_en, r_rd_en, aw_rd_en, ar_rd_en};
    rd_exp = (k == 1) ? 4'(1 << gch) : 4'b0000;
    chk("rd_en", rd_obs, rd_exp);
    chk("busy", busy, k != 0);
    chk("trace_valid", trace_valid, k >= 3);
    chk("drain_cnt", drain_cnt, exp_cnt);
    if (k >= 3) begin
      chk("trace_data", trace_data, gdata);
      chk("trace_src", trace_src, gch);
      chk("trace_urgent", trace_urgent, gurg);
    end
    pop_ch = -1;
    k_next = k;
    case (k)
      0: begin
        p = pick();
        if (enable && p >= 0) begin
          gch = p; gurg = (fsize(p) >= CAP); gdata = mem[p][head[p] % 64];
          k_next = 1;
        end
      end
      1: begin pop_ch = gch; k_next = 2; end
      2: k_next = 3;
      default: begin
        if (trace_ready) begin
          k_next = 0; last = gch;
          if (exp_cnt < MAXCNT) exp_cnt++;
          src_log.push_back(2'(gch)); urg_log.push_back(gurg); data_log.push_back(gdata);
        end
      end
    endcase
    @(posedge clk);
    #1;
    if (pop_ch >= 0) begin
      v = mem[pop_ch][head[pop_ch] % 64];
      head[pop_ch]++;
      case (pop_ch)
        0: ar_dout = v[31:0];
        1: aw_dout = v[31:0];
        2: r_dout  = v;
        default: w_dout = v;
      endcase
    end
    k = k_next;
    update_flags();
    @(negedge clk);
  endtask

  // Reset applied at a negedge; outputs must clear in the same cycle.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_trace_valid", trace_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", {w_rd_en, r_rd_en, aw_rd_en, ar_rd_en}, 0);
    chk("rst_urgent", trace_urgent, 0);
    chk("rst_src", trace_src, 0);
    chk("rst_data", trace_data, 0);
    chk("rst_cnt", drain_cnt, 0);
    k = 0; last = 3; exp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_until_k(int target, int budget, string tag);
    int n;
    n = 0;
    while (k != target && n < budget) begin cycle(); n++; end
    chk(tag, k, target);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    for (int c = 0; c < 4; c++) begin head[c] = 0; tail[c] = 0; end
    k = 0; last = 3; exp_cnt = 0; gch = 0; gurg = 1'b0; gdata = '0;
    rst_n = 1'b0; enable = 1'b0; trace_ready = 1'b0;
    ar_dout = '0; aw_dout = '0; r_dout = '0; w_dout = '0;
    update_flags();
    @(negedge clk);
    do_reset();

    // Single AR entry
    push(0, 64'h0000_1000);
    enable = 1'b1; trace_ready = 1'b1;
    repeat (8) cycle();
    chk("single_cnt", drain_cnt, 1);
    chk("single_n", data_log.size(), 1);
    if (data_log.size() > 0) begin
      chk("single_data", data_log[0], 64'h1000);
      chk("single_src", src_log[0], 0);
    end

    // Round-robin over four non-full FIFOs, two entries each
    do_reset(); flush();
    for (int c = 0; c < 4; c++) begin push_rand(c); push_rand(c); end
    repeat (40) cycle();
    chk("rr_cnt", drain_cnt, 8);
    chk("rr_n", src_log.size(), 8);
    for (int i = 0; i < 8 && i < src_log.size(); i++) chk("rr_order", src_log[i], i % 4);

    // Full W beats non-full AR/AW/R
    do_reset(); flush();
    push_rand(0); push_rand(1); push_rand(2);
    push_rand(3); push_rand(3); push_rand(3);
    repeat (24) cycle();
    chk("fp_n", src_log.size() >= 4, 1);
    if (src_log.size() >= 4) begin
      chk("fp_src0", src_log[0], 3); chk("fp_urg0", urg_log[0], 1);
      chk("fp_src1", src_log[1], 0); chk("fp_urg1", urg_log[1], 0);
      chk("fp_src2", src_log[2], 1); chk("fp_urg2", urg_log[2], 0);
      chk("fp_src3", src_log[3], 2); chk("fp_urg3", urg_log[3], 0);
    end

    // Backpressure: ten stalled SEND cycles
    do_reset(); flush();
    push_rand(0); push_rand(1);
    trace_ready = 1'b0;
    run_until_k(3, 10, "bp_reach_send");
    repeat (10) cycle();
    chk("bp_cnt_hold", drain_cnt, 0);
    trace_ready = 1'b1;
    cycle();
    chk("bp_cnt_after", drain_cnt, 1);

    // Enable dropped while in LATCH
    enable = 1'b1;
    run_until_k(2, 10, "en_reach_latch");
    enable = 1'b0;
    repeat (12) cycle();
    chk("en_cnt", drain_cnt, 2);
    chk("en_idle", busy, 0);

    // Reset while SEND is stalled
    flush();
    push_rand(2);
    enable = 1'b1; trace_ready = 1'b0;
    run_until_k(3, 10, "rs_reach_send");
    do_reset();
    flush();

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      int c;
      c = $urandom_range(0, 3);
      if ($urandom_range(0, 2) == 0 && fsize(c) < 6) push_rand(c);
      enable      = ($urandom_range(0, 7) != 0);
      trace_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    // Counter saturation after 20 deliveries
    do_reset(); flush();
    enable = 1'b1; trace_ready = 1'b1;
    for (int i = 0; i < 20; i++) push_rand(i % 4);
    repeat (100) cycle();
    chk("sat_n", data_log.size(), 20);
    chk("sat_cnt", drain_cnt, 4'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/axi_spy_drain_arb.md
AXI_SPY_DRAIN_ARB -- requirements
Module: axi_spy_drain_arb

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, giving the width of the AR and AW spy FIFO data.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 64, giving the width of the R and W spy FIFO data and of trace_data.
REQ-003 The block SHALL have parameter CNT_WIDTH, default 16, giving the width of drain_cnt.
REQ-004 Port clk, input, 1 bit: clock; all logic is on its rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 Port enable, input, 1 bit: when 1, the block may start new drains.
REQ-007 Ports ar_empty, aw_empty, r_empty and w_empty, input, 1 bit each: spy FIFO empty flags.
REQ-008 Ports ar_full, aw_full, r_full and w_full, input, 1 bit each: spy FIFO full flags.
REQ-009 Ports ar_rd_en, aw_rd_en, r_rd_en and w_rd_en, output, 1 bit each: spy FIFO pop strobes.
REQ-010 Ports ar_dout and aw_dout, input, ADDR_WIDTH bits; ports r_dout and w_dout, input, DATA_WIDTH bits: spy FIFO read data, valid in the cycle after the rd_en cycle.
REQ-011 Port trace_valid, output, 1 bit: the trace entry is valid.
REQ-012 Port trace_ready, input, 1 bit: the sink accepts the trace entry.
REQ-013 Port trace_data, output, DATA_WIDTH bits: trace payload.
REQ-014 Port trace_src, output, 2 bits: source channel, encoded 0=AR, 1=AW, 2=R, 3=W.
REQ-015 Port trace_urgent, output, 1 bit: the source FIFO was full when it was granted.
REQ-016 Port busy, output, 1 bit: the FSM is not in IDLE.
REQ-017 Port drain_cnt, output, CNT_WIDTH bits: count of delivered trace entries.

Function
REQ-018 The FSM SHALL have four states: IDLE, FETCH, LATCH and SEND.
REQ-019 In IDLE, at a rising edge with enable=1 and at least one empty=0, the FSM SHALL register the winning channel in grant, register its full flag in urgent, and move to FETCH.
REQ-020 Arbitration SHALL consider full non-empty channels before non-full ones, and SHALL use round-robin within each class.
REQ-021 Round-robin search SHALL start at last_grant+1 modulo 4, in the order AR, AW, R, W.
REQ-022 In FETCH, exactly one <grant>_rd_en SHALL be 1 for that single cycle, and the FSM SHALL then move to LATCH unconditionally.
REQ-023 All rd_en outputs SHALL be 0 in every state other than FETCH.
REQ-024 In LATCH, at the next rising edge, trace_data SHALL capture the granted dout, and the FSM SHALL move to SEND.
REQ-025 AR and AW dout SHALL be zero-extended to DATA_WIDTH when captured.
REQ-026 trace_src SHALL equal grant during SEND.
REQ-027 trace_urgent SHALL equal the registered urgent flag during SEND.
REQ-028 In SEND, trace_valid SHALL be 1, and trace_data, trace_src and trace_urgent SHALL hold stable until trace_ready=1 at a rising edge.
REQ-029 On the SEND handshake the FSM SHALL return to IDLE, set last_grant to grant, and increment drain_cnt, saturating at all-ones.
REQ-030 trace_valid SHALL be 0 in all states other than SEND.
REQ-031 Latency from the IDLE decision edge to trace_valid=1 SHALL be 2 cycles, and the minimum drain rate SHALL be one entry per 4 cycles.
REQ-032 Deasserting enable mid-drain SHALL NOT abort the drain: the current entry completes, and no new grant is made while enable=0.
REQ-033 empty and full changes after the grant SHALL NOT affect the drain in progress.
REQ-034 busy SHALL be 1 in FETCH, LATCH and SEND.

Reset
REQ-035 While rst_n=0, the FSM SHALL be in IDLE, and all rd_en, trace_valid, trace_urgent and busy outputs SHALL be 0.
REQ-036 While rst_n=0, trace_data SHALL be 0, trace_src SHALL be 0, drain_cnt SHALL be 0, and last_grant SHALL be 3, so AR has first priority.
REQ-037 Reset asserted mid-drain SHALL discard the in-flight entry immediately, with no further rd_en and no handshake.

Verification
REQ-038 Single entry: only ar_empty=0, ar_dout=32'h0000_1000, trace_ready=1 -> ar_rd_en high 1 cycle; trace_valid 2 cycles after the grant edge; trace_data=64'h1000; trace_src=0; drain_cnt=1.
REQ-039 Round-robin: all four FIFOs hold 2 entries each, none full -> trace_src sequence 0,1,2,3,0,1,2,3; drain_cnt=8.
REQ-040 Full priority: AR, AW and R non-empty, w_empty=0, w_full=1 -> first trace_src=3 with trace_urgent=1, then 0, 1, 2 with trace_urgent=0.
REQ-041 Backpressure: trace_ready=0 for 10 cycles in SEND -> trace_valid, trace_data and trace_src are stable; no rd_en pulses; drain_cnt is unchanged until the handshake.
REQ-042 Enable and reset: enable drops during LATCH -> the entry is still delivered, then the block stays in IDLE; rst_n low during SEND -> trace_valid=0 and drain_cnt=0 in the same cycle.
REQ-043 Saturation: with CNT_WIDTH=4, 20 entries delivered -> drain_cnt=4'hF.
